// File: rtl/spinet_master.sv
// spinet_master: SPI mode-0 initiator for one spinet ring port; define SPINET_MASTER_DROP_EMPTY_EN to drop received words whose valid bit is clear
module spinet_master #(
    parameter int WIDTH  = 14,
    parameter int CLKDIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             MOSI,
    output logic             SCLK,
    output logic             SS,
    input  logic             MISO
);
    localparam int HW = $clog2(CLKDIV) + 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [HW-1:0] HLAST = HW'(CLKDIV - 1);
    localparam logic [BW-1:0] BLAST = BW'(WIDTH);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE, GAP} state_t;

    state_t           state, state_n;
    logic [HW-1:0]    hcnt, hcnt_n;
    logic [BW-1:0]    bcnt, bcnt_n;
    logic [WIDTH-1:0] shift, shift_n, rx_data_n;
    logic             rx_valid_n, hlast, keep;

    assign hlast = hcnt == HLAST;
`ifdef SPINET_MASTER_DROP_EMPTY_EN
    assign keep = shift[WIDTH-1];
`else
    assign keep = 1'b1;
`endif

    // pin and handshake outputs are pure decodes of registered state, so they cannot glitch
    assign tx_ready = state == IDLE;
    assign busy     = state != IDLE;
    assign SS       = !(state == SETUP || state == HIGH || state == LOW);
    assign SCLK     = state == HIGH;
    assign MOSI     = !SS && shift[WIDTH-1];

    // state register; async reset drops SS and SCLK at once and leaves rx_data cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            hcnt     <= '0;
            bcnt     <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_n;
            hcnt     <= hcnt_n;
            bcnt     <= bcnt_n;
            shift    <= shift_n;
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
        end
    end

    // sequencing: every non-idle state lasts CLKDIV cycles; DONE is the first cycle of the gap
    always_comb begin
        state_n    = state;
        hcnt_n     = hlast ? '0 : hcnt + 1'b1;
        bcnt_n     = bcnt;
        shift_n    = shift;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        case (state)
            IDLE: begin
                hcnt_n = '0;
                if (tx_valid) begin
                    state_n = SETUP;
                    shift_n = tx_data;
                    bcnt_n  = '0;
                end
            end
            SETUP: state_n = hlast ? HIGH : SETUP;
            HIGH: begin
                if (hlast) begin
                    state_n = LOW;
                    shift_n = {shift[WIDTH-2:0], MISO};
                    bcnt_n  = bcnt + 1'b1;
                end
            end
            LOW: begin
                if (hlast) begin
                    state_n    = (bcnt == BLAST) ? DONE : HIGH;
                    rx_valid_n = (bcnt == BLAST) && keep;
                    rx_data_n  = rx_valid_n ? shift : rx_data;
                end
            end
            DONE, GAP: state_n = hlast ? IDLE : GAP;
            default:   state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spinet_master.sv
// tb_spinet_master: vector table, random frames and corner sequences for spinet_master
module tb_spinet_master;
    localparam int W  = 14;
    localparam int CD = 2;
    localparam int FL = CD * (2 * W + 1);
`ifdef SPINET_MASTER_DROP_EMPTY_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] node;
        logic         exp_v;
        logic [W-1:0] exp_rx;
    } vec_t;

    logic         clk = 1'b0, rst = 1'b0;
    logic [W-1:0] tx_data = '0, rx_data;
    logic         tx_valid = 1'b0, tx_ready, rx_valid, busy, mosi, sclk, ss, miso = 1'b0;
    logic [3:0]   tx_data2 = '0, rx_data2;
    logic         tx_valid2 = 1'b0, tx_ready2, rx_valid2, busy2, mosi2, sclk2, ss2;
    logic         miso2 = 1'b1;

    int ncmp = 0, nerr = 0, cyc = 0;
    logic [W-1:0] node_word = '0;
    int   falls_q[$], rise_q[$], rxc_q[$], rdy_q[$];
    logic mosi_q[$];
    logic [W-1:0] rxd_q[$];
    int   sslow = 0, nfalls = 0;
    logic pss = 1'b1, psclk = 1'b0, prdy = 1'b1;
    int   ss2low = 0, rv2n = 0, rv2c = -1;

    spinet_master #(.WIDTH(W), .CLKDIV(CD)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .MOSI(mosi), .SCLK(sclk),
        .SS(ss), .MISO(miso)
    );

    spinet_master #(.WIDTH(4), .CLKDIV(1)) dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2), .MOSI(mosi2), .SCLK(sclk2),
        .SS(ss2), .MISO(miso2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // node model (shifts out node_word MSB first, advancing on SCLK falls) and event log
    always @(negedge clk) begin
        if (ss) nfalls = 0;
        else if (psclk && !sclk) nfalls++;
        miso = (!ss && nfalls < W) ? node_word[W-1-nfalls] : 1'b0;
        if (pss && !ss) falls_q.push_back(cyc);
        if (!psclk && sclk) begin
            mosi_q.push_back(mosi);
            rise_q.push_back(cyc);
        end
        if (rx_valid) begin
            rxd_q.push_back(rx_data);
            rxc_q.push_back(cyc);
        end
        if (!prdy && tx_ready) rdy_q.push_back(cyc);
        if (!ss) sslow++;
        if (!ss2) ss2low++;
        if (rx_valid2) begin
            rv2n++;
            rv2c = cyc;
        end
        psclk = sclk;
        pss   = ss;
        prdy  = tx_ready;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        ncmp++;
        nerr++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic clear_log();
        falls_q.delete();
        rise_q.delete();
        rxc_q.delete();
        rdy_q.delete();
        mosi_q.delete();
        rxd_q.delete();
        sslow = 0;
    endtask

    task automatic start_frame(input logic [W-1:0] tx, input logic [W-1:0] node, output int a);
        int t = 0;
        node_word = node;
        @(posedge clk); #1;
        while (!tx_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!tx_ready) timeout("ready_before_frame");
        clear_log();
        tx_data  = tx;
        tx_valid = 1'b1;
        a = cyc;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [W-1:0] tx, input logic [W-1:0] node, output int a);
        int t = 0;
        start_frame(tx, node, a);
        while (rdy_q.size() == 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (rdy_q.size() == 0) timeout("frame_end");
    endtask

    task automatic check_frame(input string tag, input logic [W-1:0] tx, input logic exp_v,
                               input logic [W-1:0] exp_rx, input int a);
        logic [W-1:0] w = '0;
        foreach (mosi_q[i]) w = {w[W-2:0], mosi_q[i]};
        chk({tag, "_ss_fall"}, falls_q.size() == 1 ? falls_q[0] : -1, a + 1);
        chk({tag, "_ss_low"}, sslow, FL);
        chk({tag, "_rises"}, mosi_q.size(), W);
        chk({tag, "_first_rise"}, rise_q.size() > 0 ? rise_q[0] : -1, a + CD + 1);
        chk({tag, "_mosi"}, 32'(w), 32'(tx));
        chk({tag, "_rx_valid_cnt"}, rxd_q.size(), 32'(exp_v));
        if (rxd_q.size() > 0) begin
            chk({tag, "_rx_valid_cyc"}, rxc_q[0], a + FL + 1);
            chk({tag, "_rx_strobe_data"}, 32'(rxd_q[0]), 32'(exp_rx));
        end
        chk({tag, "_rx_data"}, 32'(rx_data), 32'(exp_rx));
        chk({tag, "_ready_cyc"}, rdy_q.size() > 0 ? rdy_q[0] : -1, a + FL + 1 + CD);
    endtask

    function automatic logic model_valid(input logic [W-1:0] n);
        return !DROP || n[W-1];
    endfunction

    initial begin
        vec_t vecs[5];
        int a;
        logic [W-1:0] model_rx, tx, node, w;
        logic v;
        vecs[0] = '{14'h3123, 14'h2A5C, 1'b1, 14'h2A5C};
        vecs[1] = '{14'h0000, 14'h3FFF, 1'b1, 14'h3FFF};
        vecs[2] = '{14'h3FFF, 14'h0000, !DROP, DROP ? 14'h3FFF : 14'h0000};
        vecs[3] = '{14'h2AAA, 14'h0123, !DROP, DROP ? 14'h3FFF : 14'h0123};
        vecs[4] = '{14'h1555, 14'h2001, 1'b1, 14'h2001};

        tx_valid = 1'b1;
        tx_data  = 14'h3FFF;
        repeat (3) @(negedge clk);
        chk("reset_ss", ss, 1);
        chk("reset_sclk", sclk, 0);
        chk("reset_mosi", mosi, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rx_data", 32'(rx_data), 0);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("release_tx_ready", tx_ready, 1);
        chk("release_no_frame", falls_q.size(), 0);

        foreach (vecs[i]) begin
            run_frame(vecs[i].tx, vecs[i].node, a);
            check_frame($sformatf("vec%0d", i), vecs[i].tx, vecs[i].exp_v, vecs[i].exp_rx, a);
        end

        model_rx = vecs[4].exp_rx;
        for (int i = 0; i < 20; i++) begin
            tx   = W'($urandom_range(0, (1 << W) - 1));
            node = W'($urandom_range(0, (1 << W) - 1));
            v = model_valid(node);
            if (v) model_rx = node;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_frame(tx, node, a);
            check_frame($sformatf("rnd%0d", i), tx, v, model_rx, a);
        end

        node_word = 14'h2ABC;
        @(posedge clk); #1;
        clear_log();
        tx_data  = 14'h1234;
        tx_valid = 1'b1;
        a = cyc;
        @(posedge clk); #1;
        tx_data = 14'h0F0F;
        repeat (61) @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (130) @(posedge clk);
        #1;
        w = '0;
        for (int i = 0; i < W && i < mosi_q.size(); i++) w = {w[W-2:0], mosi_q[i]};
        chk("b2b_frames", falls_q.size(), 2);
        chk("b2b_spacing", falls_q.size() == 2 ? falls_q[1] - falls_q[0] : -1, 61);
        chk("b2b_first_fall", falls_q.size() > 0 ? falls_q[0] : -1, a + 1);
        chk("b2b_first_word", 32'(w), 32'h1234);
        w = '0;
        for (int i = W; i < 2 * W && i < mosi_q.size(); i++) w = {w[W-2:0], mosi_q[i]};
        chk("b2b_second_word", 32'(w), 32'h0F0F);
        chk("b2b_rx_count", rxd_q.size(), 2);

        @(posedge clk); #1;
        ss2low = 0;
        rv2n = 0;
        rv2c = -1;
        tx_data2  = 4'h5;
        tx_valid2 = 1'b1;
        a = cyc;
        @(posedge clk); #1;
        tx_valid2 = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("div1_ss_low", ss2low, 9);
        chk("div1_rx_valid_cnt", rv2n, 1);
        chk("div1_rx_valid_cyc", rv2c, a + 10);
        chk("div1_rx_data", 32'(rx_data2), 32'hF);
        chk("div1_ready", tx_ready2, 1);

        start_frame(14'h3123, 14'h2A5C, a);
        while (cyc < a + 20) begin
            @(posedge clk); #1;
        end
        #1;
        chk("midrst_pre_ss", ss, 0);
        chk("midrst_pre_sclk", sclk, 1);
        rst = 1'b0;
        #1;
        chk("midrst_ss", ss, 1);
        chk("midrst_sclk", sclk, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rx_valid", rx_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        chk("midrst_no_strobe", rxd_q.size(), 0);
        chk("midrst_rx_data", 32'(rx_data), 0);
        chk("midrst_no_restart", falls_q.size(), 1);
        chk("midrst_ready", tx_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/spinet_master.md
# spinet_master

SPI initiator for one port of the spinet ring. It drives the MOSI/SCLK/SS pins of a spinode slave port and receives that node's MISO. Each frame is a full-duplex exchange of one WIDTH-bit word: the host word is loaded through a valid/ready handshake, and the word shifted back is presented on a one-cycle strobe. One instance sits on the host side of each ring port that is to be driven on-chip or from a test harness.

## Interface
- WIDTH, 14, frame length in bits; must equal the spinode WIDTH; ≥2
- CLKDIV, 2, SCLK half-period in clk cycles; ≥1
- clk  input  1  system clock, same clock as the spinet
- rst  input  1  asynchronous, active-low reset
- tx_data  input  WIDTH  word to send, MSB first; bit WIDTH-1 is the packet valid bit
- tx_valid  input  1  tx_data is offered
- tx_ready  output  1  master is idle and accepts tx_data this cycle
- rx_data  output  WIDTH  last word received from MISO
- rx_valid  output  1  one-cycle strobe: rx_data updated
- busy  output  1  frame or inter-frame gap in progress
- MOSI  output  1  serial data to node
- SCLK  output  1  serial clock to node; idles low
- SS  output  1  slave select, active low
- MISO  input  1  serial data from node

## Operation
- Reset (rst=0, asynchronous): state=IDLE, SS=1, SCLK=0, MOSI=0, rx_data=0, rx_valid=0, busy=0. tx_ready=1 once rst=1.
- Mode 0 SPI: MOSI changes while SCLK is low. MISO is sampled on the last clk cycle of each SCLK-high half-period. Bits go MSB first in both directions.
- No MISO synchronizer: the node shares clk.
- States:
  - IDLE: tx_ready=1. On tx_valid&tx_ready, capture tx_data into the shift register and go to SETUP.
  - SETUP: SS=0, SCLK=0, MOSI=shift[WIDTH-1], for CLKDIV cycles. Then HIGH.
  - HIGH: SCLK=1 for CLKDIV cycles. On the final cycle, shift in MISO at the LSB and increment the bit count. Then LOW.
  - LOW: SCLK=0 for CLKDIV cycles. MOSI presents the next bit from the first LOW cycle. If the bit count is WIDTH, go to DONE; otherwise go to HIGH.
  - DONE (1 cycle): SS=1, MOSI=0, rx_data←shift register, rx_valid=1. Then GAP.
  - GAP: SS=1 for CLKDIV cycles total, counting the DONE cycle. Then IDLE.
- A half-period counter of width clog2(CLKDIV)+1 and a bit counter of width clog2(WIDTH+1) control the sequence.
- busy=1 in every state except IDLE. tx_ready is the decode of state==IDLE, so it is low for the whole frame and the gap.
- tx_valid outside IDLE is ignored; the word is not queued.
- rx_data holds its value until the next DONE.
- Async reset mid-frame: SS rises immediately, SCLK=0, no rx_valid, no partial rx_data update.

## Timing
- The accept cycle is cycle 0. SS falls at the clk edge ending cycle 0; outputs are registered.
- SS is low for CLKDIV·(2·WIDTH+1) cycles.
- rx_valid is asserted in the cycle SS rises, which is cycle CLKDIV·(2·WIDTH+1)+1.
- tx_ready returns CLKDIV cycles after that.
- Defaults (WIDTH=14, CLKDIV=2):
  - SS low cycles 1–58
  - first SCLK rise at cycle 3
  - rx_valid at cycle 59
  - tx_ready high again at cycle 61
  - back-to-back throughput: one word per 61 cycles.
- CLKDIV=1: SCLK toggles every clk cycle. Each half-period is exactly one cycle.

## Configuration
- SPINET_MASTER_DROP_EMPTY_EN defined:
  - When the received word has bit WIDTH-1 = 0 (empty slot from the node), rx_valid is suppressed and rx_data keeps its previous value.
  - Frame timing is unchanged.
- Undefined: every completed frame updates rx_data and pulses rx_valid, regardless of content.

## Test plan
- Reset: hold rst=0, then drive tx_valid=1 with rst still 0. Required: SS=1, SCLK=0, MOSI=0, rx_valid=0, no frame starts. After rst=1: tx_ready=1.
- Single frame, defaults, with a node model that returns 14'h2A5C: send tx_data=14'h3123.
  - MOSI at each SCLK rise reads 1,1,0,0,0,1,0,0,1,0,0,0,1,1.
  - Exactly 14 SCLK rises.
  - rx_valid at cycle 59 with rx_data=14'h2A5C.
  - tx_ready at cycle 61.
- Back-to-back: tx_valid held high with two words. Required: the second SS fall occurs 61 cycles after the first; tx_valid is ignored while busy.
- CLKDIV=1, WIDTH=4, MISO tied 1: send 4'h5. Required: SS low 9 cycles, rx_data=4'hF, rx_valid one cycle.
- Reset mid-frame: assert rst=0 at cycle 20. Required: SS=1 and SCLK=0 immediately, no rx_valid, rx_data=0 after release.
- With SPINET_MASTER_DROP_EMPTY_EN, node returns 14'h0123 and then 14'h2001. Required: no rx_valid for the first frame; rx_valid with rx_data=14'h2001 for the second. Without the macro, both frames pulse rx_valid.
